uart_tx_fifo: RTL and testbench

Dual-write transmit FIFO between the two IO store ports of the dual-issue core and the UART emitter. Both IO ports can hit the UART data register in the same cycle. The block captures both bytes in program order (port a before port b), buffers them, and drains them one at a time through a valid/ready handshake into the emitter. It also supplies the busy and empty status used by the IO read mux and by halt gating.

---
 rtl/uart_fifo_pkg.sv | 16 +
 rtl/uart_fifo_ram.sv | 28 ++
 rtl/uart_tx_fifo.sv | 89 ++++++++
 tb/tb_uart_tx_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART transmit FIFO: default geometry and the
// IO-space bit/word indices used by the read mux and halt decode.
package uart_fifo_pkg;

    localparam int DW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 16;

    // Status-word bit that carries the FIFO full flag.
    localparam int UART_BUSY_BIT = 9;

    // IO word-address bit indices.
    localparam int UART_DATA_WORD = 1;
    localparam int UART_STAT_WORD = 2;
    localparam int HALT_WORD      = 3;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DW register array with two independent write ports and one
// asynchronous read port; the controller never aims both ports at one entry.
module uart_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] wa_addr,
    input  logic [DW-1:0] wa_data,
    input  logic          wa_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          wb_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wa_en) mem[wa_addr] <= wa_data;
        if (wb_en) mem[wb_addr] <= wb_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Dual-write transmit FIFO feeding the UART emitter; port a is ordered before port b.
// Optional sticky overflow flag built only when UART_FIFO_OVF_EN is defined.
module uart_tx_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          a_wr,
    input  logic [DW-1:0] a_data,
    input  logic          b_wr,
    input  logic [DW-1:0] b_data,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          ovf
);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] free;
    logic          a_ok, b_ok, pop;
    logic [DW-1:0] head;

    // Room is judged on the occupancy at the start of the cycle, so a pop
    // never makes space for a push in the same cycle.
    assign free = CW'(DEPTH) - count;
    assign a_ok = a_wr && (free >= CW'(1));
    assign b_ok = b_wr && (a_wr ? (free >= CW'(2)) : (free >= CW'(1)));

    // Handshake: tx_valid/tx_data are driven only from registered state and hold
    // until the rising edge where tx_valid & tx_ready, which retires the head.
    assign pop      = tx_valid && tx_ready;
    assign tx_valid = (count != '0);
    assign tx_data  = tx_valid ? head : '0;
    assign empty    = (count == '0);
    assign full     = (free < CW'(2));

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wa_addr (wr_ptr),
        .wa_data (a_data),
        .wa_en   (a_ok),
        .wb_addr (a_ok ? wr_ptr + AW'(1) : wr_ptr),
        .wb_data (b_data),
        .wb_en   (b_ok),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(a_ok) + AW'(b_ok);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(a_ok) + CW'(b_ok) - CW'(pop);
        end
    end

`ifdef UART_FIFO_OVF_EN
    logic drop;
    logic ovf_q;

    assign drop = (a_wr && !a_ok) || (b_wr && !b_ok);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   ovf_q <= 1'b0;
        else if (drop) ovf_q <= 1'b1;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: ordering, dual writes, fill/overflow,
// backpressure and asynchronous reset.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef UART_FIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          a_wr = 1'b0;
    logic [DW-1:0] a_data = '0;
    logic          b_wr = 1'b0;
    logic [DW-1:0] b_data = '0;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovf;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q[$];

    uart_tx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .a_wr     (a_wr),
        .a_data   (a_data),
        .b_wr     (b_wr),
        .b_data   (b_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", ovf); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        tx_ready = 1'b1;
        a_wr = 1'b1; a_data = 8'h48;
        tick();
        a_wr = 1'b0;
        b_wr = 1'b1; b_data = 8'h69;
        vectors++; if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid0 got %b want 1", tx_valid); end
        vectors++; if (tx_data !== 8'h48) begin miscompares++; $display("FAIL single_data0 got %h want 48", tx_data); end
        tick();
        b_wr = 1'b0;
        vectors++; if (tx_data !== 8'h69) begin miscompares++; $display("FAIL single_data1 got %h want 69", tx_data); end
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL single_count got %0d want 1", count); end
        tick();
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL single_empty got %b want 1", empty); end
        tx_ready = 1'b0;
    endtask

    task automatic test_dual();
        a_wr = 1'b1; a_data = 8'h41;
        b_wr = 1'b1; b_data = 8'h42;
        tick();
        a_wr = 1'b0; b_wr = 1'b0;
        vectors++; if (count !== 5'd2) begin miscompares++; $display("FAIL dual_count got %0d want 2", count); end
        vectors++; if (tx_data !== 8'h41) begin miscompares++; $display("FAIL dual_head0 got %h want 41", tx_data); end
        tx_ready = 1'b1;
        tick();
        vectors++; if (tx_data !== 8'h42) begin miscompares++; $display("FAIL dual_head1 got %h want 42", tx_data); end
        tick();
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL dual_empty got %b want 1", empty); end
        tx_ready = 1'b0;
    endtask

    task automatic test_fill_and_pushpop();
        exp_q.delete();
        for (int i = 0; i < DEPTH - 1; i++) begin
            a_wr = 1'b1; a_data = 8'h10 + 8'(i);
            exp_q.push_back(8'h10 + 8'(i));
            tick();
        end
        a_wr = 1'b0;
        vectors++; if (count !== 5'd15) begin miscompares++; $display("FAIL fill_count15 got %0d want 15", count); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full got %b want 1", full); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL fill_ovf_pre got %b want 0", ovf); end
        a_wr = 1'b1; a_data = 8'h55;
        b_wr = 1'b1; b_data = 8'h66;
        exp_q.push_back(8'h55);
        tick();
        a_wr = 1'b0; b_wr = 1'b0;
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL fill_count16 got %0d want 16", count); end
        vectors++; if (ovf !== OVF_EXP) begin miscompares++; $display("FAIL fill_ovf got %b want %b", ovf, OVF_EXP); end
        // Pop and a write together while full: pop happens, the write is lost.
        tx_ready = 1'b1;
        a_wr = 1'b1; a_data = 8'h99;
        tick();
        a_wr = 1'b0; tx_ready = 1'b0;
        void'(exp_q.pop_front());
        vectors++; if (count !== 5'd15) begin miscompares++; $display("FAIL pushpop_count got %0d want 15", count); end
        vectors++; if (ovf !== OVF_EXP) begin miscompares++; $display("FAIL pushpop_ovf got %b want %b", ovf, OVF_EXP); end
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            vectors++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin miscompares++; $display("FAIL drain_data got %b/%h want 1/%h", tx_valid, tx_data, exp_q[0]); end
            tick();
            void'(exp_q.pop_front());
        end
        tx_ready = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b want 1", empty); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        int            xfers;
        exp_q.delete();
        a_wr = 1'b1; a_data = 8'hC1;
        b_wr = 1'b1; b_data = 8'hC2;
        tick();
        b_wr = 1'b0; a_data = 8'hC3;
        tick();
        a_wr = 1'b0;
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
        vectors++; if (count !== 5'd3) begin miscompares++; $display("FAIL bp_count got %0d want 3", count); end
        xfers = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tx_ready = cyc[0];
            held = tx_data;
            if (exp_q.size() > 0) begin
                vectors++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin miscompares++; $display("FAIL bp_head got %b/%h want 1/%h", tx_valid, tx_data, exp_q[0]); end
            end
            tick();
            if (tx_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                xfers++;
            end else if (exp_q.size() > 0) begin
                vectors++; if (tx_data !== held) begin miscompares++; $display("FAIL bp_stable got %h want %h", tx_data, held); end
            end
        end
        tx_ready = 1'b0;
        vectors++; if (xfers !== 3) begin miscompares++; $display("FAIL bp_xfers got %0d want 3", xfers); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL bp_empty got %b want 1", empty); end
    endtask

    task automatic test_async_reset();
        a_wr = 1'b1; a_data = 8'hA1;
        b_wr = 1'b1; b_data = 8'hA2;
        tick();
        a_data = 8'hA3; b_data = 8'hA4;
        tick();
        b_wr = 1'b0; a_data = 8'hA5;
        tick();
        a_wr = 1'b0;
        vectors++; if (count !== 5'd5) begin miscompares++; $display("FAIL ar_count5 got %0d want 5", count); end
        tx_ready = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid got %b want 0", tx_valid); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL ar_empty got %b want 1", empty); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL ar_count got %0d want 0", count); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ar_ovf got %b want 0", ovf); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL ar_data got %h want 00", tx_data); end
        #2;
        resetn = 1'b1;
        tx_ready = 1'b0;
        tick();
        a_wr = 1'b1; a_data = 8'h7A;
        tick();
        a_wr = 1'b0;
        vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'h7A) begin miscompares++; $display("FAIL ar_head got %b/%h want 1/7a", tx_valid, tx_data); end
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL ar_count1 got %0d want 1", count); end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_dual();
        test_fill_and_pushpop();
        test_backpressure();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
